// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// State, source and byte-width definitions.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_arb_state_t;

  typedef enum logic {
    CPU,
    ECHO
  } tx_src_t;

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// Synchronous byte FIFO with combinational head read.
// Push is ignored when full, pop is ignored when empty.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_BYTE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)
      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push)
      count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter
// between a CPU write FIFO and the receive echo path.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_wr,
  input  logic [7:0]             cpu_data,
  output logic                   cpu_full,
  output logic [$clog2(DEPTH):0] cpu_count,
  output logic                   ovf,
  input  logic                   ovf_clr,
  input  logic                   echo_valid,
  input  logic [7:0]             echo_data,
  output logic                   echo_clear,
  output logic [7:0]             tx_byte,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   tx_err,
  output logic                   irq_tx_empty
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_arb_state_t          state_q, state_d;
  tx_src_t                last_q, last_d;
  logic [UART_BYTE_W-1:0] byte_q, byte_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic                   pop, grant_echo, err_set;
  logic                   fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_head;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cpu_wr),
    .din_i   (cpu_data),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (cpu_full),
    .empty_o (fifo_empty),
    .count_o (cpu_count)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    grant_echo = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // CPU wins unless echo is also waiting and CPU went last.
        if (!fifo_empty && (!echo_valid || last_q == ECHO)) begin
          byte_d  = fifo_head;
          last_d  = CPU;
          pop     = 1'b1;
          state_d = START;
        end else if (echo_valid) begin
          byte_d     = echo_data;
          last_d     = ECHO;
          grant_echo = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    err_d = err_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end
    if (cpu_wr && cpu_full) ovf_d = 1'b1;
    if (err_set)            err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ECHO;
      byte_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign tx_byte      = byte_q;
  assign tx_start     = (state_q == START);
  assign echo_clear   = grant_echo && !rst;
  assign ovf          = ovf_q;
  assign tx_err       = err_q;
  assign irq_tx_empty = (state_q == IDLE) && fifo_empty && !echo_valid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter,
// with transmitter and echo-mapper models.
module tb_uart_tx_arbiter;

  localparam int DEPTH  = 4;
  localparam int TO     = 8;
  localparam int M_NORM = 0;
  localparam int M_HOLD = 1;
  localparam int M_NEV  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_data = 8'h00;
  logic       cpu_full;
  logic [2:0] cpu_count;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  logic       echo_valid = 1'b0;
  logic [7:0] echo_data = 8'h00;
  logic       echo_clear;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       tx_err;
  logic       irq_tx_empty;

  uart_tx_arbiter #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_wr       (cpu_wr),
    .cpu_data     (cpu_data),
    .cpu_full     (cpu_full),
    .cpu_count    (cpu_count),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr),
    .echo_valid   (echo_valid),
    .echo_data    (echo_data),
    .echo_clear   (echo_clear),
    .tx_byte      (tx_byte),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .tx_err       (tx_err),
    .irq_tx_empty (irq_tx_empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int mode = M_NORM;
  int busy_len = 3;
  int busy_cnt = 0;
  bit start_flag = 0;
  bit clr_seen = 0;
  bit echo_pend = 0;
  int clr_cnt = 0;
  int ec_cyc = 0;
  int ev_cyc = 0;
  int cpu_started = 0;

  logic [7:0] echo_q[$];
  logic [7:0] sent_b[$];
  bit         sent_src[$];
  int         st_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe DUT mid-cycle: record starts and echo clears.
  always @(negedge clk) begin
    if (!rst) begin
      if (echo_clear) begin
        clr_cnt++;
        ec_cyc = cyc;
        clr_seen = 1;
        echo_pend = 1;
      end
      if (tx_start) begin
        sent_b.push_back(tx_byte);
        sent_src.push_back(echo_pend);
        st_cyc.push_back(cyc);
        if (!echo_pend) cpu_started++;
        echo_pend = 0;
        start_flag = 1;
      end
    end
  end

  // Transmitter and receive-mapper behaviour, driven after each edge.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      tx_busy = 0;
      echo_valid = 0;
      busy_cnt = 0;
      start_flag = 0;
      clr_seen = 0;
      echo_pend = 0;
    end else begin
      if (mode == M_HOLD) begin
        tx_busy = 1;
        start_flag = 0;
      end else if (mode == M_NEV) begin
        tx_busy = 0;
        start_flag = 0;
      end else begin
        if (start_flag) begin
          busy_cnt = busy_len;
          start_flag = 0;
        end
        tx_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
      end
      if (clr_seen) begin
        echo_valid = 0;
        clr_seen = 0;
      end else if (!echo_valid && echo_q.size() > 0) begin
        echo_data = echo_q.pop_front();
        echo_valid = 1;
        ev_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    cpu_wr = 1;
    cpu_data = d;
    @(negedge clk);
    cpu_wr = 0;
  endtask

  task automatic wait_sent(input int n, input string tag);
    int k = 0;
    while (sent_b.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, sent_b.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(irq_tx_empty && !tx_busy && echo_q.size() == 0)
           && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, irq_tx_empty, 1);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp_cpu[$];
    logic [7:0] exp_echo[$];
    logic [7:0] got_cpu[$];
    logic [7:0] got_echo[$];
    int base, cs0, pushed, s1, c0, k;

    repeat (3) @(negedge clk);
    chk("rst_start", tx_start, 0);
    chk("rst_byte", tx_byte, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_count", cpu_count, 0);
    chk("rst_full", cpu_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_eclr", echo_clear, 0);
    chk("rst_irq", irq_tx_empty, 1);

    // single CPU byte and its latency
    busy_len = 10;
    cpu_wr = 1;
    cpu_data = 8'h41;
    @(negedge clk);
    cpu_wr = 0;
    chk("t1_count", cpu_count, 1);
    chk("t1_early", tx_start, 0);
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    chk("t1_byte", tx_byte, 8'h41);
    chk("t1_irq0", irq_tx_empty, 0);
    @(negedge clk);
    chk("t1_nostart", tx_start, 0);
    chk("t1_irqbusy", irq_tx_empty, 0);
    wait_idle("t1_idle");
    chk("t1_busy", tx_busy, 0);
    chk("t1_nsent", sent_b.size(), 1);

    // overflow while the transmitter is held busy
    mode = M_HOLD;
    wr(8'hF0);
    wait_sent(2, "t2_f0");
    for (int i = 1; i <= 5; i++) wr(i[7:0]);
    chk("t2_full", cpu_full, 1);
    chk("t2_count", cpu_count, 4);
    chk("t2_ovf", ovf, 1);
    busy_len = 2;
    mode = M_NORM;
    wait_sent(6, "t2_n");
    chk("t2_b0", sent_b[1], 8'hF0);
    for (int i = 1; i <= 4; i++)
      chk("t2_seq", sent_b[i+1], i);
    wait_idle("t2_idle");
    repeat (5) @(negedge clk);
    chk("t2_drop", sent_b.size(), 6);
    chk("t2_ovfkeep", ovf, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("t2_ovfclr", ovf, 0);

    // echo latency, then a round-robin tie
    mode = M_HOLD;
    echo_q.push_back(8'h33);
    wait_sent(7, "t3_echo");
    chk("t3_b33", sent_b[6], 8'h33);
    chk("t3_src", sent_src[6], 1);
    chk("t3_clrlat", ec_cyc, ev_cyc);
    chk("t3_stlat", st_cyc[6], ev_cyc + 1);
    wr(8'h10);
    wr(8'h11);
    echo_q.push_back(8'h55);
    repeat (3) @(negedge clk);
    chk("t3_count", cpu_count, 2);
    c0 = clr_cnt;
    busy_len = 2;
    mode = M_NORM;
    wait_sent(10, "t3_n");
    chk("t3_g0", sent_b[7], 8'h10);
    chk("t3_g1", sent_b[8], 8'h55);
    chk("t3_g2", sent_b[9], 8'h11);
    wait_idle("t3_idle");
    chk("t3_clrs", clr_cnt - c0, 1);

    // busy timeout
    mode = M_NEV;
    wr(8'h77);
    wr(8'h78);
    wait_sent(11, "t4_first");
    s1 = st_cyc[10];
    k = 0;
    while (!tx_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t4_errcyc", cyc, s1 + TO + 1);
    wait_sent(12, "t4_second");
    chk("t4_gap", st_cyc[11] - s1, TO + 2);
    chk("t4_b0", sent_b[10], 8'h77);
    chk("t4_b1", sent_b[11], 8'h78);
    mode = M_NORM;
    wait_idle("t4_idle");
    chk("t4_err", tx_err, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("t4_errclr", tx_err, 0);

    // reset in the middle of a transfer
    mode = M_HOLD;
    wr(8'h90);
    wait_sent(13, "t5_start");
    wr(8'h91);
    wr(8'h92);
    chk("t5_q2", cpu_count, 2);
    rst = 1;
    #1;
    chk("t5_start", tx_start, 0);
    chk("t5_count", cpu_count, 0);
    chk("t5_byte", tx_byte, 0);
    @(negedge clk);
    rst = 0;
    mode = M_NORM;
    repeat (20) @(negedge clk);
    chk("t5_quiet", sent_b.size(), 13);
    wr(8'h93);
    wait_sent(14, "t5_new");
    chk("t5_b93", sent_b[13], 8'h93);
    wait_idle("t5_idle");

    // push and pop in the same cycle
    mode = M_HOLD;
    wr(8'hA0);
    wait_sent(15, "t6_a0");
    wr(8'hA1);
    wr(8'hA2);
    chk("t6_pre", cpu_count, 2);
    mode = M_NORM;
    @(negedge clk);
    @(negedge clk);
    cpu_wr = 1;
    cpu_data = 8'h22;
    chk("t6_cnt2", cpu_count, 2);
    @(negedge clk);
    cpu_wr = 0;
    chk("t6_same", cpu_count, 2);
    chk("t6_start", tx_start, 1);
    chk("t6_byte", tx_byte, 8'hA1);
    wait_sent(18, "t6_n");
    chk("t6_o1", sent_b[16], 8'hA2);
    chk("t6_o2", sent_b[17], 8'h22);
    wait_idle("t6_idle");

    // randomized mix, checked per source order
    base = sent_b.size();
    cs0 = cpu_started;
    pushed = 0;
    for (int i = 0; i < 400; i++) begin
      busy_len = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1 &&
          pushed - (cpu_started - cs0) < DEPTH) begin
        d = 8'($urandom);
        cpu_wr = 1;
        cpu_data = d;
        exp_cpu.push_back(d);
        pushed++;
      end else begin
        cpu_wr = 0;
      end
      if ($urandom_range(0, 9) == 0 && echo_q.size() == 0) begin
        d = 8'($urandom);
        echo_q.push_back(d);
        exp_echo.push_back(d);
      end
      @(negedge clk);
    end
    cpu_wr = 0;
    wait_idle("rnd_idle");
    for (int i = base; i < sent_b.size(); i++) begin
      if (sent_src[i]) got_echo.push_back(sent_b[i]);
      else got_cpu.push_back(sent_b[i]);
    end
    chk("rnd_ncpu", got_cpu.size(), exp_cpu.size());
    chk("rnd_necho", got_echo.size(), exp_echo.size());
    for (int i = 0; i < got_cpu.size() && i < exp_cpu.size(); i++)
      chk("rnd_cpu", got_cpu[i], exp_cpu[i]);
    for (int i = 0; i < got_echo.size() && i < exp_echo.size(); i++)
      chk("rnd_echo", got_echo[i], exp_echo[i]);
    chk("rnd_ovf", ovf, 0);
    chk("rnd_err", tx_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
